// File: rtl/punc_loader_pkg.sv
// Shared types and constants for the PUnC boot loader: frame states, sync byte,
// error codes and the memory write payload.
package punc_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned ERR_W  = 2;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_ADDR_HI = 4'd1,
        ST_ADDR_LO = 4'd2,
        ST_CNT_HI  = 4'd3,
        ST_CNT_LO  = 4'd4,
        ST_DATA_HI = 4'd5,
        ST_DATA_LO = 4'd6,
        ST_CSUM_HI = 4'd7,
        ST_CSUM_LO = 4'd8,
        ST_DONE    = 4'd9,
        ST_ERROR   = 4'd10
    } state_t;

    localparam logic [BYTE_W-1:0] LOADER_SYNC = 8'hA5;

    localparam logic [ERR_W-1:0] LOADER_ERR_NONE    = 2'd0;
    localparam logic [ERR_W-1:0] LOADER_ERR_CSUM    = 2'd1;
    localparam logic [ERR_W-1:0] LOADER_ERR_TIMEOUT = 2'd2;

    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } mem_req_t;

    // A frame is in progress from the address header through the checksum.
    function automatic logic is_busy(input state_t s);
        return (s >= ST_ADDR_HI) && (s <= ST_CSUM_LO);
    endfunction

endpackage

// File: rtl/punc_loader_timer.sv
// Inter-byte idle counter; expired flags the edge at which the idle count
// reaches TIMEOUT_CYCLES.
module punc_loader_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear || !i_enable) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Not masked by clear: a byte arriving on the expiring edge still loses.
    assign o_expired_c = i_enable && (r_cnt == LAST_CNT);

endmodule

// File: rtl/punc_loader.sv
// Boot-time frame loader: parses the byte stream, writes LC3 words to memory
// and holds the PUnC core in reset until a frame passes its checksum.
module punc_loader
    import punc_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic [1:0]  err,
    output logic        busy
);

    state_t              r_state, w_state_nx;
    logic [WORD_W-1:0]   r_base, w_base_nx;
    logic [WORD_W-1:0]   r_cnt, w_cnt_nx;
    logic [WORD_W-1:0]   r_index, w_index_nx;
    logic [WORD_W-1:0]   r_xor, w_xor_nx;
    logic [BYTE_W-1:0]   r_hi, w_hi_nx;
    logic [BYTE_W-1:0]   r_csum_hi, w_csum_hi_nx;
    mem_req_t            r_req, w_req_nx;
    logic                r_mem_wr, w_mem_wr_nx;
    logic                r_core_rst, w_core_rst_nx;
    logic                r_done, w_done_nx;
    logic [ERR_W-1:0]    r_err, w_err_nx;
    logic                r_busy;
    logic                r_in_ready;

    logic                w_accept;
    logic                w_expired;
    logic [WORD_W-1:0]   w_word;
    logic [WORD_W-1:0]   w_index_inc;

    assign w_accept    = in_valid && r_in_ready;
    assign w_word      = {r_hi, in_data};
    assign w_index_inc = r_index + WORD_W'(1);

    punc_loader_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_accept),
        .i_enable   (r_busy),
        .o_expired_c(w_expired)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_base     <= '0;
            r_cnt      <= '0;
            r_index    <= '0;
            r_xor      <= '0;
            r_hi       <= '0;
            r_csum_hi  <= '0;
            r_req      <= '0;
            r_mem_wr   <= 1'b0;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= LOADER_ERR_NONE;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_base     <= w_base_nx;
            r_cnt      <= w_cnt_nx;
            r_index    <= w_index_nx;
            r_xor      <= w_xor_nx;
            r_hi       <= w_hi_nx;
            r_csum_hi  <= w_csum_hi_nx;
            r_req      <= w_req_nx;
            r_mem_wr   <= w_mem_wr_nx;
            r_core_rst <= w_core_rst_nx;
            r_done     <= w_done_nx;
            r_err      <= w_err_nx;
            r_busy     <= is_busy(w_state_nx);
            r_in_ready <= 1'b1;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nx    = r_state;
        w_base_nx     = r_base;
        w_cnt_nx      = r_cnt;
        w_index_nx    = r_index;
        w_xor_nx      = r_xor;
        w_hi_nx       = r_hi;
        w_csum_hi_nx  = r_csum_hi;
        w_req_nx      = r_req;
        w_mem_wr_nx   = 1'b0;
        w_core_rst_nx = r_core_rst;
        w_done_nx     = r_done;
        w_err_nx      = r_err;

        if (w_expired) begin
            w_state_nx = ST_ERROR;
            w_err_nx   = LOADER_ERR_TIMEOUT;
        end else if (w_accept) begin
            unique case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (in_data == LOADER_SYNC) begin
                        w_state_nx    = ST_ADDR_HI;
                        w_core_rst_nx = 1'b1;
                        w_done_nx     = 1'b0;
                        w_err_nx      = LOADER_ERR_NONE;
                        w_xor_nx      = '0;
                        w_index_nx    = '0;
                    end
                end
                ST_ADDR_HI: begin
                    w_base_nx  = {in_data, r_base[BYTE_W-1:0]};
                    w_state_nx = ST_ADDR_LO;
                end
                ST_ADDR_LO: begin
                    w_base_nx  = {r_base[WORD_W-1:BYTE_W], in_data};
                    w_state_nx = ST_CNT_HI;
                end
                ST_CNT_HI: begin
                    w_cnt_nx   = {in_data, r_cnt[BYTE_W-1:0]};
                    w_state_nx = ST_CNT_LO;
                end
                ST_CNT_LO: begin
                    w_cnt_nx   = {r_cnt[WORD_W-1:BYTE_W], in_data};
                    w_state_nx = ({r_cnt[WORD_W-1:BYTE_W], in_data} == '0) ? ST_CSUM_HI
                                                                            : ST_DATA_HI;
                end
                ST_DATA_HI: begin
                    w_hi_nx    = in_data;
                    w_state_nx = ST_DATA_LO;
                end
                ST_DATA_LO: begin
                    w_mem_wr_nx   = 1'b1;
                    w_req_nx.addr = r_base + r_index;
                    w_req_nx.data = w_word;
                    w_index_nx    = w_index_inc;
                    w_xor_nx      = r_xor ^ w_word;
                    w_state_nx    = (w_index_inc == r_cnt) ? ST_CSUM_HI : ST_DATA_HI;
                end
                ST_CSUM_HI: begin
                    w_csum_hi_nx = in_data;
                    w_state_nx   = ST_CSUM_LO;
                end
                ST_CSUM_LO: begin
                    if ({r_csum_hi, in_data} == r_xor) begin
                        w_state_nx    = ST_DONE;
                        w_done_nx     = 1'b1;
                        w_core_rst_nx = 1'b0;
                    end else begin
                        w_state_nx = ST_ERROR;
                        w_err_nx   = LOADER_ERR_CSUM;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_req.addr;
    assign mem_wdata = r_req.data;
    assign core_rst  = r_core_rst;
    assign done      = r_done;
    assign err       = r_err;
    assign busy      = r_busy;

endmodule

// File: doc/punc_loader.md
# punc_loader

Boot-time program loader for the PUnC LC3 system. Consumes a framed byte stream (host link, testbench or UART front end) and writes 16-bit LC3 words into the shared memory through its write port. Holds the PUnC core in reset until a frame passes its checksum, then releases it. It is the writer side of the memory the control unit fetches from.

## Interface
Parameters:
- TIMEOUT_CYCLES, 65535: maximum idle cycles between accepted bytes inside a frame before the frame aborts; legal range 1..65535.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  byte available on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts byte; transfer when in_valid & in_ready at posedge
- mem_wr  output  1  one-cycle write strobe to memory
- mem_addr  output  16  write address
- mem_wdata  output  16  write data
- core_rst  output  1  reset to PUnC core; 1 until a good frame completes
- done  output  1  level, last frame loaded and verified
- err  output  2  0 none, 1 checksum mismatch, 2 inter-byte timeout
- busy  output  1  frame in progress (states ADDR_HI..CSUM_LO)

## Operation
- Frame, big-endian: SYNC 0xA5, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, CNT data words (HI then LO), CSUM_HI, CSUM_LO. CSUM = XOR of all data words; CNT=0 requires CSUM 0x0000.
- States: IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO, DONE, ERROR. Each accepted byte advances one state. CNT_LO goes to CSUM_HI if count is 0, else DATA_HI. DATA_LO goes to DATA_HI while words remain, else CSUM_HI.
- IDLE, DONE, ERROR: accept and discard every byte except 0xA5. 0xA5 goes to ADDR_HI, sets core_rst=1, clears done and err, and clears the running XOR.
- Data write: on acceptance of a DATA_LO byte, register mem_wr=1, mem_addr=base+index (mod 2^16, wraps 0xFFFF to 0x0000), and mem_wdata={hi,lo}. index increments and the running XOR updates.
- CSUM_LO accepted: on match go to DONE (done=1, core_rst=0). On mismatch go to ERROR with err=1.
- Timeout: an idle counter resets on every accepted byte and counts while busy. When it reaches TIMEOUT_CYCLES, go to ERROR with err=2. Memory writes already issued are not undone.
- in_ready=1 in every state after reset. Memory is assumed to always accept a write.

## Timing
- Reset values: state IDLE, in_ready=0 during reset cycle then 1, mem_wr=0, mem_addr=0, mem_wdata=0, core_rst=1, done=0, err=0, busy=0.
- All outputs are registered.
- Write latency: a DATA_LO byte accepted at edge k gives mem_wr high for cycle k..k+1. The write lands at edge k+1. mem_wr is never high for two consecutive cycles, because each word needs two byte transfers.
- Release: CSUM_LO accepted at edge n gives done=1 and core_rst=0 from edge n. The last write always lands before release.
- Sync byte in DONE: core_rst returns to 1 at the accepting edge.
- rst mid-frame: immediate return to reset values, no further writes, partial frame discarded.
- Timeout fires at the edge where the idle count equals TIMEOUT_CYCLES. A byte accepted at that same edge loses, and ERROR wins.

## Structure
- Shared defines header (Defines.v additions) holds:
  - the state encodings;
  - LOADER_SYNC = 8'hA5;
  - error codes LOADER_ERR_NONE/CSUM/TIMEOUT.
- One sub-module: punc_loader_timer, the idle counter with clear, enable and expired outputs, parameterised by TIMEOUT_CYCLES.
- FSM, address/index counters and XOR accumulator live in punc_loader.

## Test plan
- Good frame: A5 30 00 00 02 12 34 F0 0F E2 3B gives writes 0x3000=0x1234 and 0x3001=0xF00F, then done=1, core_rst=0, err=0.
- Bad checksum: same frame with CSUM E2 3C gives both writes issued, then err=1, done=0, core_rst=1. A following good frame recovers.
- Wrap: A5 FF FF 00 02 AA AA 55 55 FF FF gives writes 0xFFFF=0xAAAA and 0x0000=0x5555, then done=1.
- Timeout, with TIMEOUT_CYCLES=16: A5 30 00 followed by silence gives err=2 exactly 16 cycles after the last byte, busy=0, core_rst=1.
- Empty frame: A5 40 00 00 00 00 00 gives no mem_wr and done=1. The same frame with CSUM 00 01 gives err=1.
- Noise and reset: bytes 00 13 FF before A5 are ignored and the frame loads correctly. rst asserted between two DATA words gives no further mem_wr, all outputs at reset values, and core_rst=1.
